// File: rtl/mmio_console.sv
// Console MMIO slave: halt, integer print, status and a character FIFO drained by a UART transmitter.
// Build with MMIO_CONSOLE_PARITY_EN defined to add an even-parity bit to every frame.

// state  | meaning
// IDLE   | line high, waiting for the FIFO to hold a character
// START  | start bit (low) for BAUD_DIV cycles
// DATA   | eight data bits, LSB first, BAUD_DIV cycles each
// PARITY | even parity of the data bits (parity build only)
// STOP   | stop bit (high); pops the next character at its end if one is waiting
module mmio_console #(
   parameter int FIFO_DEPTH = 16,
   parameter int BAUD_DIV   = 868
) (
   input  logic        phi1,
   input  logic        rst_n,
   input  logic [55:0] data_address,
   input  logic [1:0]  data_size,
   input  logic [63:0] output_data,
   input  logic        output_data_request,
   output logic        output_data_complete,
   input  logic        input_data_request,
   output logic [63:0] input_data,
   output logic        input_data_valid,
   output logic        mmio_hit,
   output logic        tx,
   output logic        halt,
   output logic        int_valid,
   output logic [63:0] int_data
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   localparam logic [55:0] ADDR_HALT   = 56'hFF_FFFF_FFFF_FFF8;
   localparam logic [55:0] ADDR_CHAR   = 56'hFF_FFFF_FFFF_FFFC;
   localparam logic [55:0] ADDR_PRINT  = 56'hFF_FFFF_FFFF_FFF0;
   localparam logic [55:0] ADDR_STATUS = 56'hFF_FFFF_FFFF_FFE8;

`ifdef MMIO_CONSOLE_PARITY_EN
   localparam logic PARITY_FLAG = 1'b1;
`else
   localparam logic PARITY_FLAG = 1'b0;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   tx_state_t         state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shift_reg;
`ifdef MMIO_CONSOLE_PARITY_EN
   logic              parity_bit;
`endif

   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic             fifo_full;
   logic [7:0]       fifo_head;
   logic [7:0]       count8;

   logic sel_halt;
   logic sel_char;
   logic sel_print;
   logic sel_status;
   logic wr_fire;
   logic push;
   logic pop;
   logic baud_done;
   logic busy;
   logic [63:0] status_word;
   logic unused_size;

   // Access width is accepted for any register; only the address selects behaviour.
   assign unused_size = ^data_size;

   assign mmio_hit   = &data_address[55:8];
   assign sel_halt   = (data_address == ADDR_HALT);
   assign sel_char   = (data_address == ADDR_CHAR);
   assign sel_print  = (data_address == ADDR_PRINT);
   assign sel_status = (data_address == ADDR_STATUS);

   assign fifo_empty = (fifo_count == '0);
   assign fifo_full  = (fifo_count == CNT_FULL);
   assign fifo_head  = fifo_mem[rd_ptr];
   assign count8     = 8'(fifo_count);

   assign output_data_complete = output_data_request & mmio_hit & ~(sel_char & fifo_full);
   assign wr_fire              = output_data_request & output_data_complete;
   assign push                 = wr_fire & sel_char;

   assign baud_done = (baud_cnt == BAUD_LAST);
   assign busy      = (state != ST_IDLE);
   assign pop       = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_done));

   assign status_word      = {48'd0, count8, 3'd0, PARITY_FLAG, halt, busy, fifo_full, fifo_empty};
   assign input_data_valid = input_data_request & mmio_hit;
   assign input_data       = (mmio_hit & sel_status) ? status_word : 64'd0;

   always_ff @(posedge phi1) begin
      if (push) begin
         fifo_mem[wr_ptr] <= output_data[7:0];
      end
   end

   always_ff @(posedge phi1 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge phi1 or negedge rst_n) begin
      if (!rst_n) begin
         halt      <= 1'b0;
         int_valid <= 1'b0;
         int_data  <= 64'd0;
      end else begin
         int_valid <= wr_fire & sel_print;
         if (wr_fire & sel_halt) begin
            halt <= 1'b1;
         end
         if (wr_fire & sel_print) begin
            int_data <= output_data;
         end
      end
   end

   always_ff @(posedge phi1 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         tx        <= 1'b1;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
`ifdef MMIO_CONSOLE_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  shift_reg <= fifo_head;
`ifdef MMIO_CONSOLE_PARITY_EN
                  parity_bit <= ^fifo_head;
`endif
                  baud_cnt  <= '0;
                  tx        <= 1'b0;
                  state     <= ST_START;
               end else begin
                  tx <= 1'b1;
               end
            end
            ST_START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shift_reg[0];
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            ST_DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef MMIO_CONSOLE_PARITY_EN
                     tx    <= parity_bit;
                     state <= ST_PARITY;
`else
                     tx    <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_idx   <= bit_idx + 3'd1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     tx        <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
`ifdef MMIO_CONSOLE_PARITY_EN
            ST_PARITY: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= ST_STOP;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
`endif
            ST_STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  // Chain straight into the next start bit so queued frames have no idle gap.
                  if (pop) begin
                     shift_reg <= fifo_head;
`ifdef MMIO_CONSOLE_PARITY_EN
                     parity_bit <= ^fifo_head;
`endif
                     tx        <= 1'b0;
                     state     <= ST_START;
                  end else begin
                     tx    <= 1'b1;
                     state <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_console.sv
// Scoreboard bench for mmio_console: expected characters and print values are queued at write time
// and compared against what the tx-line and int_valid monitors observe.
module tb_mmio_console;

   localparam int BD = 4;
   localparam int FD = 4;
`ifdef MMIO_CONSOLE_PARITY_EN
   localparam int          FRAME  = 11 * BD;
   localparam logic [63:0] ST_PAR = 64'h10;
`else
   localparam int          FRAME  = 10 * BD;
   localparam logic [63:0] ST_PAR = 64'h0;
`endif

   localparam logic [55:0] A_HALT   = 56'hFF_FFFF_FFFF_FFF8;
   localparam logic [55:0] A_CHAR   = 56'hFF_FFFF_FFFF_FFFC;
   localparam logic [55:0] A_PRINT  = 56'hFF_FFFF_FFFF_FFF0;
   localparam logic [55:0] A_STATUS = 56'hFF_FFFF_FFFF_FFE8;
   localparam logic [55:0] A_RSVD   = 56'hFF_FFFF_FFFF_FFE0;
   localparam logic [55:0] A_RAM    = 56'h00_0000_0000_1000;

   logic        phi1;
   logic        rst_n;
   logic [55:0] data_address;
   logic [1:0]  data_size;
   logic [63:0] output_data;
   logic        output_data_request;
   logic        output_data_complete;
   logic        input_data_request;
   logic [63:0] input_data;
   logic        input_data_valid;
   logic        mmio_hit;
   logic        tx;
   logic        halt;
   logic        int_valid;
   logic [63:0] int_data;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0]  exp_char [$];
   logic [7:0]  obs_char [$];
   logic        obs_stop [$];
   logic        obs_par  [$];
   int          obs_start[$];
   logic [63:0] exp_int  [$];
   logic [63:0] obs_int  [$];

   logic [7:0] mon_b;
   logic       mon_s;
   logic       mon_p;
   int         mon_st;

   mmio_console #(.FIFO_DEPTH(FD), .BAUD_DIV(BD)) dut (
      .phi1                 (phi1),
      .rst_n                (rst_n),
      .data_address         (data_address),
      .data_size            (data_size),
      .output_data          (output_data),
      .output_data_request  (output_data_request),
      .output_data_complete (output_data_complete),
      .input_data_request   (input_data_request),
      .input_data           (input_data),
      .input_data_valid     (input_data_valid),
      .mmio_hit             (mmio_hit),
      .tx                   (tx),
      .halt                 (halt),
      .int_valid            (int_valid),
      .int_data             (int_data)
   );

   initial begin
      phi1 = 1'b0;
      forever #5 phi1 = ~phi1;
   end

   always @(posedge phi1) cyc <= cyc + 1;

   // tx decoder: start detected on the first low sample, each bit sampled mid-cell.
   initial begin
      mon_p = 1'b0;
      forever begin
         @(negedge phi1);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            mon_st = cyc;
            repeat (BD + BD / 2) @(negedge phi1);
            for (int i = 0; i < 8; i++) begin
               mon_b[i] = tx;
               if (i < 7) repeat (BD) @(negedge phi1);
            end
`ifdef MMIO_CONSOLE_PARITY_EN
            repeat (BD) @(negedge phi1);
            mon_p = tx;
`endif
            repeat (BD) @(negedge phi1);
            mon_s = tx;
            obs_char.push_back(mon_b);
            obs_stop.push_back(mon_s);
            obs_par.push_back(mon_p);
            obs_start.push_back(mon_st);
            repeat (BD / 2 - 1) @(negedge phi1);
         end
      end
   end

   always @(negedge phi1) begin
      if (int_valid === 1'b1) obs_int.push_back(int_data);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cpu_write(input logic [55:0] a, input logic [63:0] d, output int edge_no, output int waits);
      @(negedge phi1);
      data_address        = a;
      output_data         = d;
      data_size           = 2'd3;
      output_data_request = 1'b1;
      waits               = 0;
      #1;
      while (output_data_complete !== 1'b1 && waits < 200) begin
         @(negedge phi1);
         #1;
         waits++;
      end
      @(posedge phi1);
      #1;
      edge_no             = cyc;
      output_data_request = 1'b0;
   endtask

   task automatic cpu_read(input logic [55:0] a, output logic hit, output logic valid, output logic [63:0] d);
      @(negedge phi1);
      data_address       = a;
      data_size          = 2'd3;
      input_data_request = 1'b1;
      #1;
      hit   = mmio_hit;
      valid = input_data_valid;
      d     = input_data;
      @(posedge phi1);
      #1;
      input_data_request = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int t;
      t = 0;
      while (obs_char.size() < n && t < FRAME * (n + 2) + 100) begin
         @(negedge phi1);
         t++;
      end
      if (obs_char.size() < n) begin
         n_vec++;
         n_err++;
         $display("FAIL frame_timeout: got %0d frames, expected %0d", obs_char.size(), n);
      end
   endtask

   task automatic test_reset();
      logic h, v;
      logic [63:0] d;
      int e, w;
      @(negedge phi1);
      #1;
      n_vec++;
      if (tx !== 1'b1 || halt !== 1'b0 || int_valid !== 1'b0 || int_data !== 64'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got tx=%b halt=%b iv=%b id=%h, expected 1 0 0 0", tx, halt, int_valid, int_data);
      end
      cpu_read(A_STATUS, h, v, d);
      n_vec++;
      if (d !== (64'h1 | ST_PAR)) begin
         n_err++;
         $display("FAIL reset_status: got %h expected %h", d, 64'h1 | ST_PAR);
      end
      cpu_write(A_HALT, 64'd1, e, w);
      cpu_write(A_CHAR, 64'h55, e, w);
      repeat (10) @(posedge phi1);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (tx !== 1'b1 || halt !== 1'b0) begin
         n_err++;
         $display("FAIL reset_midframe: got tx=%b halt=%b, expected tx=1 halt=0", tx, halt);
      end
      repeat (2) @(negedge phi1);
      rst_n = 1'b1;
      cpu_read(A_STATUS, h, v, d);
      n_vec++;
      if (d !== (64'h1 | ST_PAR)) begin
         n_err++;
         $display("FAIL reset_status_after: got %h expected %h", d, 64'h1 | ST_PAR);
      end
      repeat (FRAME + 10) @(negedge phi1);
      obs_char.delete();
      obs_stop.delete();
      obs_par.delete();
      obs_start.delete();
      exp_char.delete();
   endtask

   task automatic test_char();
      logic h, v;
      logic [63:0] d;
      logic [7:0] ec, oc;
      int k, w, low, st;
      cpu_write(A_CHAR, 64'hABCD_0041, k, w);
      exp_char.push_back(8'h41);
      n_vec++;
      if (w !== 0) begin
         n_err++;
         $display("FAIL char_complete: got %0d wait cycles, expected 0", w);
      end
      low = 0;
      for (int i = 0; i < BD; i++) begin
         @(posedge phi1);
         #1;
         if (tx === 1'b0) low++;
      end
      n_vec++;
      if (low !== BD) begin
         n_err++;
         $display("FAIL char_start_len: got %0d low cycles, expected %0d", low, BD);
      end
      @(posedge phi1);
      #1;
      n_vec++;
      if (tx !== 1'b1) begin
         n_err++;
         $display("FAIL char_bit0: got %b expected 1", tx);
      end
      // Now at edge k+BD+1; move to edge k+FRAME (last stop cycle).
      repeat (FRAME - BD - 1) @(posedge phi1);
      cpu_read(A_STATUS, h, v, d);
      n_vec++;
      if (d !== (64'h5 | ST_PAR)) begin
         n_err++;
         $display("FAIL char_busy_last: got %h expected %h", d, 64'h5 | ST_PAR);
      end
      cpu_read(A_STATUS, h, v, d);
      n_vec++;
      if (d !== (64'h1 | ST_PAR)) begin
         n_err++;
         $display("FAIL char_idle_after: got %h expected %h", d, 64'h1 | ST_PAR);
      end
      wait_frames(1);
      if (obs_char.size() > 0) begin
         ec = exp_char.pop_front();
         oc = obs_char.pop_front();
         st = obs_start.pop_front();
         n_vec++;
         if (oc !== ec || obs_stop[0] !== 1'b1 || st !== k + 1) begin
            n_err++;
            $display("FAIL char_frame: got byte=%h stop=%b start=%0d, expected byte=%h stop=1 start=%0d",
                     oc, obs_stop[0], st, ec, k + 1);
         end
`ifdef MMIO_CONSOLE_PARITY_EN
         n_vec++;
         if (obs_par[0] !== ^ec) begin
            n_err++;
            $display("FAIL char_parity: got %b expected %b", obs_par[0], ^ec);
         end
`endif
         void'(obs_stop.pop_front());
         void'(obs_par.pop_front());
      end
   endtask

   task automatic test_back_to_back();
      int e[6];
      int w[6];
      int st;
      logic [7:0] ec, oc;
      logic sb, pb;
      for (int i = 0; i < 6; i++) begin
         cpu_write(A_CHAR, 64'(8'h60 + i), e[i], w[i]);
         exp_char.push_back(8'(8'h60 + i));
      end
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (w[i] !== 0 || e[i] !== e[0] + i) begin
            n_err++;
            $display("FAIL b2b_accept%0d: got waits=%0d edge=%0d, expected waits=0 edge=%0d", i, w[i], e[i], e[0] + i);
         end
      end
      n_vec++;
      if (e[5] !== e[0] + FRAME + 2) begin
         n_err++;
         $display("FAIL b2b_stall: got accept edge %0d, expected %0d", e[5], e[0] + FRAME + 2);
      end
      wait_frames(6);
      for (int i = 0; i < 6; i++) begin
         if (obs_char.size() > 0 && exp_char.size() > 0) begin
            ec = exp_char.pop_front();
            oc = obs_char.pop_front();
            sb = obs_stop.pop_front();
            pb = obs_par.pop_front();
            st = obs_start.pop_front();
            n_vec++;
            if (oc !== ec || sb !== 1'b1 || st !== e[0] + 1 + i * FRAME) begin
               n_err++;
               $display("FAIL b2b_frame%0d: got byte=%h stop=%b start=%0d, expected byte=%h stop=1 start=%0d",
                        i, oc, sb, st, ec, e[0] + 1 + i * FRAME);
            end
`ifdef MMIO_CONSOLE_PARITY_EN
            n_vec++;
            if (pb !== ^ec) begin
               n_err++;
               $display("FAIL b2b_parity%0d: got %b expected %b", i, pb, ^ec);
            end
`endif
         end
      end
   endtask

   task automatic test_print();
      int k, w;
      logic [63:0] ev, ov;
      cpu_write(A_PRINT, 64'hFFFF_FFFF_FFFF_FFFB, k, w);
      exp_int.push_back(64'hFFFF_FFFF_FFFF_FFFB);
      n_vec++;
      if (int_valid !== 1'b1 || int_data !== 64'hFFFF_FFFF_FFFF_FFFB) begin
         n_err++;
         $display("FAIL print_pulse: got iv=%b id=%h, expected iv=1 id=fffffffffffffffb", int_valid, int_data);
      end
      @(posedge phi1);
      #1;
      n_vec++;
      if (int_valid !== 1'b0) begin
         n_err++;
         $display("FAIL print_width: got iv=%b one cycle later, expected 0", int_valid);
      end
      cpu_write(A_PRINT, 64'h0123_4567_89AB_CDEF, k, w);
      exp_int.push_back(64'h0123_4567_89AB_CDEF);
      cpu_write(A_PRINT, 64'h0000_0000_0000_002A, k, w);
      exp_int.push_back(64'h0000_0000_0000_002A);
      repeat (3) @(negedge phi1);
      n_vec++;
      if (obs_int.size() !== 3) begin
         n_err++;
         $display("FAIL print_count: got %0d valid cycles, expected 3", obs_int.size());
      end
      while (obs_int.size() > 0 && exp_int.size() > 0) begin
         ev = exp_int.pop_front();
         ov = obs_int.pop_front();
         n_vec++;
         if (ov !== ev) begin
            n_err++;
            $display("FAIL print_value: got %h expected %h", ov, ev);
         end
      end
      n_vec++;
      if (int_data !== 64'h2A) begin
         n_err++;
         $display("FAIL print_hold: got %h expected %h", int_data, 64'h2A);
      end
   endtask

   task automatic test_halt();
      int k, w;
      logic h, v;
      logic [63:0] d;
      logic [7:0] ec, oc;
      n_vec++;
      if (halt !== 1'b0) begin
         n_err++;
         $display("FAIL halt_before: got %b expected 0", halt);
      end
      cpu_write(A_HALT, 64'h0, k, w);
      n_vec++;
      if (halt !== 1'b1) begin
         n_err++;
         $display("FAIL halt_set: got %b expected 1", halt);
      end
      cpu_read(A_STATUS, h, v, d);
      n_vec++;
      if (d !== (64'h9 | ST_PAR) || v !== 1'b1) begin
         n_err++;
         $display("FAIL halt_status: got %h valid=%b, expected %h valid=1", d, v, 64'h9 | ST_PAR);
      end
      cpu_write(A_CHAR, 64'h5A, k, w);
      exp_char.push_back(8'h5A);
      n_vec++;
      if (w !== 0) begin
         n_err++;
         $display("FAIL halt_char_complete: got %0d wait cycles, expected 0", w);
      end
      wait_frames(1);
      if (obs_char.size() > 0) begin
         ec = exp_char.pop_front();
         oc = obs_char.pop_front();
         void'(obs_start.pop_front());
         void'(obs_par.pop_front());
         n_vec++;
         if (oc !== ec || obs_stop.pop_front() !== 1'b1) begin
            n_err++;
            $display("FAIL halt_char_frame: got %h expected %h", oc, ec);
         end
      end
      n_vec++;
      if (halt !== 1'b1) begin
         n_err++;
         $display("FAIL halt_sticky: got %b expected 1", halt);
      end
   endtask

   task automatic test_address();
      logic h, v;
      logic [63:0] d;
      int k, w;
      cpu_read(A_RAM, h, v, d);
      n_vec++;
      if (h !== 1'b0 || v !== 1'b0 || d !== 64'd0) begin
         n_err++;
         $display("FAIL ram_read: got hit=%b valid=%b data=%h, expected 0 0 0", h, v, d);
      end
      @(negedge phi1);
      data_address        = A_RAM;
      output_data         = 64'h77;
      output_data_request = 1'b1;
      #1;
      n_vec++;
      if (output_data_complete !== 1'b0) begin
         n_err++;
         $display("FAIL ram_write: got complete=%b expected 0", output_data_complete);
      end
      @(posedge phi1);
      #1;
      output_data_request = 1'b0;
      cpu_read(A_RSVD, h, v, d);
      n_vec++;
      if (h !== 1'b1 || v !== 1'b1 || d !== 64'd0) begin
         n_err++;
         $display("FAIL rsvd_read: got hit=%b valid=%b data=%h, expected 1 1 0", h, v, d);
      end
      cpu_write(A_RSVD, 64'h1234, k, w);
      n_vec++;
      if (w !== 0) begin
         n_err++;
         $display("FAIL rsvd_write: got %0d wait cycles, expected 0", w);
      end
      cpu_read(A_STATUS, h, v, d);
      n_vec++;
      if (d !== (64'h9 | ST_PAR)) begin
         n_err++;
         $display("FAIL rsvd_no_effect: got %h expected %h", d, 64'h9 | ST_PAR);
      end
   endtask

   initial begin
      rst_n               = 1'b0;
      data_address        = '0;
      data_size           = '0;
      output_data         = '0;
      output_data_request = 1'b0;
      input_data_request  = 1'b0;
      repeat (3) @(negedge phi1);
      rst_n = 1'b1;
      test_reset();
      test_char();
      test_back_to_back();
      test_print();
      test_halt();
      test_address();
      n_vec++;
      if (exp_char.size() !== 0 || obs_char.size() !== 0) begin
         n_err++;
         $display("FAIL leftover_frames: got exp=%0d obs=%0d, expected 0 0", exp_char.size(), obs_char.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
